// File: rtl/fechadura_pkg.sv
//==============================================================================
// fechadura_pkg : shared types, defaults and config sanitising for the lock
// Rev 1.0
//==============================================================================
`default_nettype none

package fechadura_pkg;

   localparam logic [3:0] KEY_ENTER = 4'hF;
   localparam logic [6:0] MIN_T     = 7'd5;
   localparam logic [6:0] MAX_T     = 7'd60;

   // digits packed as {d1,d2,d3,d4}, d1 in the most significant nibble
   typedef struct packed {
      logic        status;
      logic [15:0] digits;
   } pinPac_t;

   typedef struct packed {
      logic       bip_status;
      logic [6:0] bip_time;
      logic [6:0] tranca_aut_time;
      pinPac_t    master_pin;
      pinPac_t    pin1;
      pinPac_t    pin2;
      pinPac_t    pin3;
      pinPac_t    pin4;
   } setupPac_t;

   typedef struct packed {
      logic [3:0] bcd0;
      logic [3:0] bcd1;
      logic [3:0] bcd2;
      logic [3:0] bcd3;
      logic [3:0] bcd4;
      logic [3:0] bcd5;
   } bcdPac_t;

   localparam setupPac_t CFG_DEFAULT = '{
      bip_status:      1'b1,
      bip_time:        7'd5,
      tranca_aut_time: 7'd5,
      master_pin:      '{status: 1'b1, digits: 16'h1234},
      pin1:            '{status: 1'b1, digits: 16'h0000},
      pin2:            '{status: 1'b0, digits: 16'h0000},
      pin3:            '{status: 1'b0, digits: 16'h0000},
      pin4:            '{status: 1'b0, digits: 16'h0000}
   };

   function automatic logic [6:0] clamp_t(input logic [6:0] t);
      if (t < MIN_T) return MIN_T;
      if (t > MAX_T) return MAX_T;
      return t;
   endfunction

   // master PIN is always enabled so setup can never become unreachable
   function automatic setupPac_t sanitize_cfg(input setupPac_t c);
      setupPac_t r;
      r                   = c;
      r.bip_time          = clamp_t(c.bip_time);
      r.tranca_aut_time   = clamp_t(c.tranca_aut_time);
      r.master_pin.status = 1'b1;
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/pin_compare.sv
//==============================================================================
// pin_compare : combinational match of a typed entry against the stored PINs
// Rev 1.0
//==============================================================================
`default_nettype none

module pin_compare
   import fechadura_pkg::*;
(
   input  logic [15:0] entry_i,
   input  pinPac_t     master_i,
   input  pinPac_t     pin1_i,
   input  pinPac_t     pin2_i,
   input  pinPac_t     pin3_i,
   input  pinPac_t     pin4_i,
   output logic        match_master_o,
   output logic        match_user_o
);

   logic [3:0] w_user_hit;

   assign match_master_o = master_i.status && (entry_i == master_i.digits);

   assign w_user_hit[0] = pin1_i.status && (entry_i == pin1_i.digits);
   assign w_user_hit[1] = pin2_i.status && (entry_i == pin2_i.digits);
   assign w_user_hit[2] = pin3_i.status && (entry_i == pin3_i.digits);
   assign w_user_hit[3] = pin4_i.status && (entry_i == pin4_i.digits);

   assign match_user_o = |w_user_hit;

endmodule

`default_nettype wire

// File: rtl/fechadura_ctrl.sv
//==============================================================================
// fechadura_ctrl : keypad door-lock controller with relock, lockout and setup
// Rev 1.0
//==============================================================================
`default_nettype none

module fechadura_ctrl
   import fechadura_pkg::*;
#(
   parameter int unsigned TICKS_PER_S = 50_000_000,
   parameter int unsigned MAX_FAILS   = 3,
   parameter int unsigned LOCKOUT_S   = 30
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_valid,
   input  logic [3:0] key_code,
   input  logic       porta_fechada,
   input  logic       botao_interno,
   input  setupPac_t  data_setup_new,
   input  logic       setup_end,
   output logic       setup_on,
   output setupPac_t  data_setup_old,
   output logic       tranca,
   output logic       bip,
   output bcdPac_t    bcd_out,
   output logic       bcd_enable
);

   localparam logic [2:0] TRAVADO      = 3'd0;
   localparam logic [2:0] VERIFICAR    = 3'd1;
   localparam logic [2:0] DESTRAVADO   = 3'd2;
   localparam logic [2:0] PORTA_ABERTA = 3'd3;
   localparam logic [2:0] BLOQUEADO    = 3'd4;
   localparam logic [2:0] SETUP_REQ    = 3'd5;
   localparam logic [2:0] SETUP_CAPT   = 3'd6;
   localparam logic [2:0] SETUP_FIM    = 3'd7;

   localparam int         TW        = (TICKS_PER_S > 1) ? $clog2(TICKS_PER_S) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_S - 1);
   localparam logic [6:0] LOCK_T    = 7'(LOCKOUT_S);
   localparam logic [3:0] FAIL_MAX  = 4'(MAX_FAILS);

   logic [2:0]    state_q, state_d;
   logic          kv_q, kv_qq, bt_q, bt_qq;
   logic [3:0]    code_q;
   logic [15:0]   buf_q, buf_d;
   logic [15:0]   entry_q, entry_d;
   logic [3:0]    fail_q, fail_d;
   logic [TW-1:0] tick_q;
   logic [6:0]    sec_q;
   setupPac_t     cfg_q, cfg_d;

   logic          key_edge, btn_edge, sec_tick;
   logic [6:0]    sec_inc;
   logic          match_master, match_user;

   assign key_edge = kv_q & ~kv_qq;
   assign btn_edge = bt_q & ~bt_qq;
   assign sec_tick = (tick_q == TICK_LAST);
   assign sec_inc  = (sec_q == 7'd127) ? sec_q : sec_q + 7'd1;

   pin_compare u_pin_compare (
      .entry_i        (entry_q),
      .master_i       (cfg_q.master_pin),
      .pin1_i         (cfg_q.pin1),
      .pin2_i         (cfg_q.pin2),
      .pin3_i         (cfg_q.pin3),
      .pin4_i         (cfg_q.pin4),
      .match_master_o (match_master),
      .match_user_o   (match_user)
   );

   always_comb begin
      state_d = state_q;
      buf_d   = buf_q;
      entry_d = entry_q;
      fail_d  = fail_q;
      cfg_d   = cfg_q;
      case (state_q)
         TRAVADO: begin
            if (btn_edge) begin
               state_d = DESTRAVADO;
            end else if (key_edge) begin
               if (code_q <= 4'd9) begin
                  buf_d = {buf_q[11:0], code_q};
               end else if (code_q == KEY_ENTER) begin
                  entry_d = buf_q;
                  buf_d   = 16'hFFFF;
                  state_d = VERIFICAR;
               end
            end
         end
         VERIFICAR: begin
            if (match_master) begin
               state_d = SETUP_REQ;
            end else if (match_user) begin
               state_d = DESTRAVADO;
               fail_d  = 4'd0;
            end else begin
               fail_d  = fail_q + 4'd1;
               state_d = (fail_d >= FAIL_MAX) ? BLOQUEADO : TRAVADO;
            end
         end
         DESTRAVADO: begin
            if (!porta_fechada) begin
               state_d = PORTA_ABERTA;
            end else if (btn_edge) begin
               state_d = TRAVADO;
            end else if (sec_tick && (sec_inc == cfg_q.tranca_aut_time)) begin
               state_d = TRAVADO;
            end
         end
         PORTA_ABERTA: begin
            if (porta_fechada) state_d = DESTRAVADO;
         end
         BLOQUEADO: begin
            if (btn_edge) begin
               state_d = DESTRAVADO;
               fail_d  = 4'd0;
            end else if (sec_tick && (sec_inc == LOCK_T)) begin
               state_d = TRAVADO;
               fail_d  = 4'd0;
            end
         end
         SETUP_REQ: begin
            if (!setup_end) state_d = SETUP_CAPT;
         end
         SETUP_CAPT: begin
            cfg_d   = sanitize_cfg(data_setup_new);
            state_d = SETUP_FIM;
         end
         SETUP_FIM: begin
            if (setup_end) state_d = TRAVADO;
         end
         default: state_d = TRAVADO;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= TRAVADO;
         kv_q    <= 1'b0;
         kv_qq   <= 1'b0;
         bt_q    <= 1'b0;
         bt_qq   <= 1'b0;
         code_q  <= 4'd0;
         buf_q   <= 16'hFFFF;
         entry_q <= 16'hFFFF;
         fail_q  <= 4'd0;
         tick_q  <= '0;
         sec_q   <= 7'd0;
         cfg_q   <= CFG_DEFAULT;
      end else begin
         state_q <= state_d;
         kv_q    <= key_valid;
         kv_qq   <= kv_q;
         bt_q    <= botao_interno;
         bt_qq   <= bt_q;
         code_q  <= key_code;
         buf_q   <= buf_d;
         entry_q <= entry_d;
         fail_q  <= fail_d;
         cfg_q   <= cfg_d;
         // every state starts its timing from zero
         if (state_d != state_q) begin
            tick_q <= '0;
            sec_q  <= 7'd0;
         end else if (sec_tick) begin
            tick_q <= '0;
            sec_q  <= sec_inc;
         end else begin
            tick_q <= tick_q + 1'b1;
         end
      end
   end

   assign tranca         = !((state_q == DESTRAVADO) || (state_q == PORTA_ABERTA));
   assign bip            = (state_q == PORTA_ABERTA) && cfg_q.bip_status &&
                           (sec_q >= cfg_q.bip_time);
   assign setup_on       = (state_q == SETUP_REQ);
   assign bcd_enable     = !((state_q == SETUP_REQ) || (state_q == SETUP_CAPT) ||
                             (state_q == SETUP_FIM));
   assign bcd_out        = (state_q == BLOQUEADO) ? bcdPac_t'(24'h000000)
                                                  : bcdPac_t'({8'hFF, buf_q});
   assign data_setup_old = cfg_q;

endmodule

`default_nettype wire

// File: doc/fechadura_ctrl.md
Name: fechadura_ctrl

Overview:
- Top-level door-lock controller for the keypad/lock FPGA design.
- Holds the active configuration (setupPac_t) and checks typed PINs against it.
- Drives the lock actuator, auto-relock timer and door-open beeper.
- Sequences the setup block through the setup_on/setup_end handshake when the master PIN is entered, then adopts the new configuration.

Parameters:
TICKS_PER_S, 50_000_000, clk cycles per second; benches use 10.
MAX_FAILS, 3, consecutive wrong PINs before keypad lockout.
LOCKOUT_S, 30, lockout duration in seconds.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
key_valid  in  1  keypad strobe; only its rising edge is used
key_code  in  4  key value: 0-9 digit, F enter, A-E ignored
porta_fechada  in  1  door contact, 1 = door closed
botao_interno  in  1  inside push button, level; only its rising edge is used
data_setup_new  in  setupPac_t  configuration returned by the setup block
setup_end  in  1  setup block status, idle-high
setup_on  out  1  request to the setup block
data_setup_old  out  setupPac_t  active configuration register
tranca  out  1  1 = locked
bip  out  1  beeper
bcd_out  out  bcdPac_t  display digits, F = blank
bcd_enable  out  1  display enable

Behaviour:
- Reset values:
  - state TRAVADO; tranca=1, bip=0, setup_on=0, bcd_enable=1.
  - bcd_out all F; digit buffer all F; fail counter 0; timers 0.
  - data_setup_old: bip_status=1, bip_time=5, tranca_aut_time=5.
  - master_pin={1,1,2,3,4}; pin1={1,0,0,0,0}; pin2..pin4 status=0, digits 0.
- Edge detection: key_valid and botao_interno are registered one cycle; actions fire on the cycle after the rising edge.
- Second tick: a free-running counter wraps at TICKS_PER_S-1 and pulses sec_tick. The counter is cleared on every state change.
- Digit entry (TRAVADO only):
  - A digit shifts into buffer d1..d4 (d1 = oldest) and is mirrored to BCD2..BCD5.
  - BCD0/BCD1 stay F.
  - Key F latches the buffer into the compare stage, refills the buffer with F, and goes to VERIFICAR.
  - An entry with fewer than 4 digits therefore contains F and never matches.
- VERIFICAR (1 cycle):
  - Master PIN match, status=1 → SETUP_REQ. Master PIN has priority over user PINs.
  - Else a match on any pinN with status=1 → DESTRAVADO. Fail counter cleared.
  - Else fail counter +1 → TRAVADO; if the counter reaches MAX_FAILS → BLOQUEADO.
- DESTRAVADO:
  - tranca=0.
  - Door closed: count sec_tick; when the count equals tranca_aut_time → TRAVADO, tranca=1.
  - Door opening → PORTA_ABERTA.
  - botao_interno edge with door closed → TRAVADO immediately.
- PORTA_ABERTA:
  - tranca=0; count seconds.
  - When bip_status=1 and the count ≥ bip_time: bip=1 until the door closes.
  - Door closing → DESTRAVADO with bip=0 and the relock counter restarted from 0.
- TRAVADO: botao_interno edge → DESTRAVADO (exit from inside, no PIN needed).
- BLOQUEADO:
  - Keys ignored; bcd_out shows all 0 as the lockout indication.
  - After LOCKOUT_S seconds → TRAVADO, fail counter 0.
  - botao_interno remains active (unlock from inside).
- Setup handshake (lock stays closed, keypad owned by the setup block):
  - SETUP_REQ: setup_on=1; wait for setup_end=0 → SETUP_CAPT.
  - SETUP_CAPT: data_setup_old ← data_setup_new on this cycle; setup_on=0 → SETUP_FIM.
  - SETUP_FIM: wait for setup_end=1 → TRAVADO; bcd_enable back to 1.
- Config sanitising on capture:
  - bip_time and tranca_aut_time are clamped to 5..60.
  - master_pin.status is forced to 1 so the device can never be locked out of setup.
- While setup_on=1, bcd_enable=0 so the setup block owns the display.
- Comparisons are 16-bit equality plus the status bit. Timers are 7-bit, saturating at 127.
- Reset asserted in any state aborts the operation: setup_on drops to 0 and the config returns to reset defaults.

Decomposition:
- Package fechadura_pkg: pinPac_t, setupPac_t, bcdPac_t, the default config constant, and the key constants KEY_ENTER=4'hF and MIN_T=5/MAX_T=60.
- One sub-module, pin_compare: combinational compare of the entry against the 5 PINs, with outputs match_master and match_user.

Test Plan:
1. Reset, then keys 1,2,3,4,F (master) → setup_on=1 two cycles after F. Model the setup block dropping setup_end with bip_time=10 → data_setup_old.bip_time=10, setup_on=0, return to TRAVADO.
2. Keys 0,0,0,0,F → tranca=0. Door closed for 5 s (50 cycles, TICKS_PER_S=10) → tranca=1 at the tick.
3. Valid PIN, open the door for 5 s → bip=1 at the 5th tick; close the door → bip=0 the next cycle and the relock count restarts.
4. Three wrong PINs (9,9,9,9,F) → BLOQUEADO, digit keys ignored. After 300 cycles → TRAVADO; a valid PIN then unlocks.
5. Keys 1,2,F → no unlock, fail count 1. Keys A-E produce no buffer change.
6. Setup returns tranca_aut_time=2 and master status=0 → stored value 5, master status 1. Assert rst during SETUP_REQ → setup_on=0 and defaults restored.
